mem_req_responder: RTL and testbench

Memory-side endpoint of the processor's AXI-Stream memory link. Accepts the serialized line request stream (header beat plus optional write-data beats), reassembles a 512-bit line request, and issues it on a single-outstanding, line-wide memory port. For reads, it returns the 512-bit line as four response beats in the format the core-side response accumulator expects.

---
 rtl/mem_req_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_req_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_responder.sv
// Memory-side endpoint of the AXI-Stream memory link: reassembles serialized
// line requests, issues them one at a time to memory and streams read lines back.
module mem_req_responder #(
  parameter int ADDR_W = 26,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 128
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_axis_valid,
  output logic              req_axis_ready,
  input  logic              req_axis_tuser,
  input  logic [BEAT_W-1:0] req_axis_data,
  output logic              resp_axis_valid,
  input  logic              resp_axis_ready,
  output logic              resp_axis_tuser,
  output logic [BEAT_W-1:0] resp_axis_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data,
  output logic              protocol_error
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    WDATA = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4
  } state_t;

  state_t              state_r;
  logic [1:0]          beat_r;
  logic [LINE_W-1:0]   line_r;
  logic                req_fire_s;
  logic                hdr_we_s;
  logic [ADDR_W-1:0]   hdr_addr_s;
  logic [1:0]          beat_nxt_s;
  logic [BEAT_W-1:0]   send_slice_s;

  assign req_fire_s = req_axis_valid & req_axis_ready;
  assign hdr_we_s   = req_axis_data[ADDR_W];
  assign hdr_addr_s = req_axis_data[ADDR_W-1:0];
  assign beat_nxt_s = beat_r + 2'd1;

  // Request channel is open only while collecting a header or write data.
  always_comb begin
    case (state_r)
      HDR, WDATA: req_axis_ready = 1'b1;
      default:    req_axis_ready = 1'b0;
    endcase
  end

  // Next response slice, selected ahead of the handshake that advances to it.
  always_comb begin
    send_slice_s = line_r[int'(beat_nxt_s)*BEAT_W +: BEAT_W];
  end

  // Sequencer: framing, single-outstanding memory issue and response serialization.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r         <= HDR;
      beat_r          <= 2'd0;
      line_r          <= '0;
      resp_axis_valid <= 1'b0;
      resp_axis_tuser <= 1'b0;
      resp_axis_data  <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_we      <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_wdata   <= '0;
      protocol_error  <= 1'b0;
    end else begin
      case (state_r)
        HDR: begin
          if (req_fire_s) begin
            if (req_axis_tuser) begin
              mem_req_we   <= hdr_we_s;
              mem_req_addr <= hdr_addr_s;
              beat_r       <= 2'd0;
              if (hdr_we_s) begin
                state_r <= WDATA;
              end else begin
                mem_req_valid <= 1'b1;
                state_r       <= ISSUE;
              end
            end else begin
              protocol_error <= 1'b1;
            end
          end
        end
        WDATA: begin
          if (req_fire_s) begin
            if (req_axis_tuser) begin
              // A header mid-line abandons the partial write and starts over.
              protocol_error <= 1'b1;
              mem_req_we     <= hdr_we_s;
              mem_req_addr   <= hdr_addr_s;
              beat_r         <= 2'd0;
              if (hdr_we_s) begin
                state_r <= WDATA;
              end else begin
                mem_req_valid <= 1'b1;
                state_r       <= ISSUE;
              end
            end else begin
              mem_req_wdata[int'(beat_r)*BEAT_W +: BEAT_W] <= req_axis_data;
              if (beat_r == LAST_BEAT) begin
                beat_r        <= 2'd0;
                mem_req_valid <= 1'b1;
                state_r       <= ISSUE;
              end else begin
                beat_r <= beat_nxt_s;
              end
            end
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_r       <= mem_req_we ? HDR : WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            line_r          <= mem_resp_data;
            resp_axis_data  <= mem_resp_data[BEAT_W-1:0];
            resp_axis_tuser <= 1'b1;
            resp_axis_valid <= 1'b1;
            beat_r          <= 2'd0;
            state_r         <= SEND;
          end
        end
        SEND: begin
          if (resp_axis_ready) begin
            if (beat_r == LAST_BEAT) begin
              resp_axis_valid <= 1'b0;
              resp_axis_tuser <= 1'b0;
              beat_r          <= 2'd0;
              state_r         <= HDR;
            end else begin
              beat_r          <= beat_nxt_s;
              resp_axis_data  <= send_slice_s;
              resp_axis_tuser <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_responder.sv
// Directed bench for mem_req_responder: a behavioural memory with random stall,
// a response collector with optional backpressure and a reference line store.
module tb_mem_req_responder;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          req_axis_valid, req_axis_ready, req_axis_tuser;
  logic [127:0]  req_axis_data;
  logic          resp_axis_valid, resp_axis_ready, resp_axis_tuser;
  logic [127:0]  resp_axis_data;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [25:0]   mem_req_addr;
  logic [511:0]  mem_req_wdata;
  logic          mem_resp_valid;
  logic [511:0]  mem_resp_data;
  logic          protocol_error;

  mem_req_responder dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_axis_valid(req_axis_valid), .req_axis_ready(req_axis_ready),
    .req_axis_tuser(req_axis_tuser), .req_axis_data(req_axis_data),
    .resp_axis_valid(resp_axis_valid), .resp_axis_ready(resp_axis_ready),
    .resp_axis_tuser(resp_axis_tuser), .resp_axis_data(resp_axis_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .protocol_error(protocol_error)
  );

  always #5 clk_in = ~clk_in;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  logic [511:0] mem_store [logic [25:0]];
  logic [511:0] ref_mem   [logic [25:0]];
  int           mem_max_delay = 0;
  int           n_issued = 0;
  logic [25:0]  last_addr;
  logic         last_we;
  logic [511:0] last_wdata;
  bit           expect_resp = 1'b1;
  int           resp_unexp = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] dflt(input logic [25:0] a);
    return {16{6'd0, a}};
  endfunction

  function automatic logic [511:0] mem_line(input logic [25:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return dflt(a);
  endfunction

  // Behavioural memory: random accept delay, stability check while stalled, next-cycle read data.
  initial begin
    bit           hs_pend = 1'b0;
    bit           stalled = 1'b0;
    int           stall_left = -1;
    logic [25:0]  cap_addr;
    logic         cap_we;
    logic [511:0] cap_wdata;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk_in);
      mem_resp_valid = 1'b0;
      if (hs_pend) begin
        hs_pend = 1'b0;
        n_issued++;
        last_addr = cap_addr; last_we = cap_we; last_wdata = cap_wdata;
        if (cap_we) mem_store[cap_addr] = cap_wdata;
        else begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_line(cap_addr);
        end
      end
      if (stalled && !rst_in) begin
        chk("mem stall valid", mem_req_valid, 1'b1);
        chk("mem stall addr", mem_req_addr, cap_addr);
        chk("mem stall we", mem_req_we, cap_we);
        chk("mem stall wdata", mem_req_wdata, cap_wdata);
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid && !rst_in) begin
        cap_addr = mem_req_addr; cap_we = mem_req_we; cap_wdata = mem_req_wdata;
        if (stall_left < 0) stall_left = $urandom_range(0, mem_max_delay);
        if (stall_left == 0) begin
          mem_req_ready = 1'b1; hs_pend = 1'b1; stall_left = -1; stalled = 1'b0;
        end else begin
          stall_left--; stalled = 1'b1;
        end
      end else stalled = 1'b0;
    end
  end

  // Flags any response beat offered while none is expected.
  initial forever begin
    @(negedge clk_in);
    if (resp_axis_valid && !expect_resp) resp_unexp++;
  end

  task automatic send_beat(input logic u, input logic [127:0] d);
    int n = 0;
    @(negedge clk_in);
    req_axis_valid = 1'b1; req_axis_tuser = u; req_axis_data = d;
    while (!req_axis_ready && n < 200) begin @(negedge clk_in); n++; end
    if (n >= 200) chk("req accept timeout", 1'b0, 1'b1);
    @(posedge clk_in); #1;
    req_axis_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic we, input logic [25:0] a);
    send_beat(1'b1, {101'd0, we, a});
  endtask

  task automatic recv_line(input logic [511:0] exp, input int stop, input bit rnd, input int exp_first);
    int k = 0, n = 0, first_n = 0;
    bit stalled = 1'b0, r;
    logic [127:0] pd;
    logic pu;
    while (k < stop && n < 400) begin
      @(negedge clk_in); n++;
      if (stalled) begin
        chk("resp stall valid", resp_axis_valid, 1'b1);
        chk("resp stall data", resp_axis_data, pd);
        chk("resp stall tuser", resp_axis_tuser, pu);
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      resp_axis_ready = r;
      if (resp_axis_valid) begin
        if (first_n == 0) first_n = n;
        if (r) begin
          chk($sformatf("resp beat %0d data", k), resp_axis_data, exp[k*128 +: 128]);
          chk($sformatf("resp beat %0d tuser", k), resp_axis_tuser, (k == 0));
          k++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; pd = resp_axis_data; pu = resp_axis_tuser;
        end
      end else stalled = 1'b0;
    end
    if (k < stop) chk("resp beat timeout", k, stop);
    if (exp_first != 0) chk("first beat latency", first_n, exp_first);
    @(negedge clk_in);
    resp_axis_ready = 1'b0;
    if (stop == 4) begin
      chk("ready after last beat", req_axis_ready, 1'b1);
      chk("valid after last beat", resp_axis_valid, 1'b0);
    end
  endtask

  task automatic wait_issued(input int target);
    int n = 0;
    while (n_issued < target && n < 200) begin @(negedge clk_in); n++; end
    chk("issue count", n_issued, target);
  endtask

  initial begin
    logic [511:0] line0, wline, exp_l;
    logic [127:0] b [4];
    logic [25:0]  a;
    logic         we;
    int           base;
    rst_in = 1'b1;
    req_axis_valid = 1'b0; req_axis_tuser = 1'b0; req_axis_data = '0;
    resp_axis_ready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst resp_valid", resp_axis_valid, 1'b0);
    chk("rst mem_req_valid", mem_req_valid, 1'b0);
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    chk("rst req_ready", req_axis_ready, 1'b1);
    chk("rst resp_tuser", resp_axis_tuser, 1'b0);
    chk("rst resp_data", resp_axis_data, 128'd0);
    chk("rst mem_we", mem_req_we, 1'b0);
    chk("rst mem_addr", mem_req_addr, 26'd0);
    chk("rst mem_wdata", mem_req_wdata, 512'd0);
    chk("rst perr", protocol_error, 1'b0);

    // Directed read with zero-latency memory.
    line0 = {128'h3, 128'h2, 128'h1, 128'h0};
    mem_store[26'h0001234] = line0;
    send_hdr(1'b0, 26'h0001234);
    chk("read mem_req t+1", mem_req_valid, 1'b1);
    chk("read req_ready low", req_axis_ready, 1'b0);
    recv_line(line0, 4, 1'b0, 3);
    chk("read addr", last_addr, 26'h0001234);
    chk("read we", last_we, 1'b0);
    chk("read issue count", n_issued, 1);

    // Directed write to the top address.
    expect_resp = 1'b0;
    wline = '0;
    send_hdr(1'b1, 26'h3FFFFFF);
    for (int k = 0; k < 4; k++) begin
      b[k] = {4{32'hA0A0_0000 + 32'(k)}};
      wline[k*128 +: 128] = b[k];
      send_beat(1'b0, b[k]);
    end
    chk("write mem_req t+1", mem_req_valid, 1'b1);
    wait_issued(2);
    chk("write addr", last_addr, 26'h3FFFFFF);
    chk("write we", last_we, 1'b1);
    chk("write wdata", last_wdata, wline);
    @(posedge clk_in); #1;
    chk("write ready back", req_axis_ready, 1'b1);
    repeat (8) @(posedge clk_in);
    chk("no resp for write", resp_unexp, 0);
    expect_resp = 1'b1;
    chk("perr still clear", protocol_error, 1'b0);

    // Data beat while waiting for a header.
    send_beat(1'b0, 128'hDEAD);
    chk("stray beat perr", protocol_error, 1'b1);
    chk("stray beat ready", req_axis_ready, 1'b1);
    repeat (4) @(posedge clk_in);
    chk("stray beat no issue", n_issued, 2);

    // Header after two write beats aborts the write; the read is served.
    send_hdr(1'b1, 26'h0000055);
    send_beat(1'b0, 128'h11);
    send_beat(1'b0, 128'h22);
    send_hdr(1'b0, 26'h0001234);
    recv_line(line0, 4, 1'b0, 0);
    chk("abort issue count", n_issued, 3);
    chk("abort served addr", last_addr, 26'h0001234);
    chk("abort served we", last_we, 1'b0);
    chk("abort not stored", mem_store.exists(26'h0000055), 1'b0);

    // Reset in the middle of a response.
    send_hdr(1'b0, 26'h0001234);
    recv_line(line0, 2, 1'b0, 0);
    chk("pre-reset perr", protocol_error, 1'b1);
    chk("pre-reset resp_valid", resp_axis_valid, 1'b1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("mid rst resp_valid", resp_axis_valid, 1'b0);
    chk("mid rst perr", protocol_error, 1'b0);
    chk("mid rst req_ready", req_axis_ready, 1'b1);
    @(negedge clk_in); rst_in = 1'b0;
    send_hdr(1'b0, 26'h3FFFFFF);
    recv_line(wline, 4, 1'b0, 0);

    // Random traffic with memory stalls and response backpressure.
    ref_mem[26'h3FFFFFF] = wline;
    ref_mem[26'h0001234] = line0;
    mem_max_delay = 5;
    base = n_issued;
    for (int i = 0; i < 100; i++) begin
      a  = 26'h0000100 + 26'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      send_hdr(we, a);
      if (we) begin
        for (int k = 0; k < 4; k++) begin
          b[k] = {$urandom, $urandom, $urandom, $urandom};
          wline[k*128 +: 128] = b[k];
          send_beat(1'b0, b[k]);
        end
        ref_mem[a] = wline;
      end else begin
        exp_l = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        recv_line(exp_l, 4, 1'b1, 0);
      end
    end
    wait_issued(base + 100);
    chk("random no stray resp", resp_unexp, 0);
    chk("random perr clear", protocol_error, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
